share_arb: RTL and testbench



---
 rtl/share_arb_pkg.sv | 19 +
 rtl/share_arb_rr_pick.sv | 37 +++
 rtl/share_arb.sv | 122 ++++++++++++
 tb/tb_share_arb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/share_arb_pkg.sv
// Shared types and constants for the share_arb round-robin resource sharer.
package share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned RES_LAT_MIN = 1;
  localparam int unsigned RES_LAT_MAX = 15;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/share_arb_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or above
// ptr, wrapping from REQ_NUM-1 back to 0. Returns one-hot grant and index.
module share_arb_rr_pick #(
  parameter int unsigned REQ_NUM = 2,
  parameter int unsigned IW      = 1
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [REQ_NUM-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [REQ_NUM-1:0] rot;
  int unsigned        pos;

  // Rotate so ptr lands at bit 0, take the lowest set bit, map back to index.
  always_comb begin
    rot   = REQ_NUM'({req, req} >> ptr);
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        pos = 32'(ptr) + k;
        if (pos >= REQ_NUM) pos = pos - REQ_NUM;
        idx = IW'(pos);
      end
    end
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (any && (idx == IW'(i))) grant[i] = 1'b1;
    end
  end

endmodule

// File: rtl/share_arb.sv
// share_arb: shares one fixed-latency resource between REQ_NUM requesters.
// One transaction at a time: accept -> issue -> wait RES_LAT -> respond.
// Optional macro SHARE_ARB_FIXED_PRIO_EN selects fixed lowest-index priority in place of round-robin.
module share_arb
  import share_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM    = 2,
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned RES_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_NUM-1:0]            req_vld,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_din,
  output logic [REQ_NUM-1:0]            req_rdy,
  output logic [REQ_NUM-1:0]            rsp_vld,
  output logic [DATA_WIDTH-1:0]         rsp_dout,
  output logic [DATA_WIDTH-1:0]         res_din,
  output logic                          res_vld,
  input  logic [DATA_WIDTH-1:0]         res_dout,
  output logic                          busy
);

  localparam int unsigned   IW       = idx_w(REQ_NUM);
  localparam int unsigned   CW       = $clog2(RES_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RES_LAT - 1);

  if (RES_LAT < RES_LAT_MIN || RES_LAT > RES_LAT_MAX) begin : g_bad_lat
    $error("share_arb: RES_LAT out of range");
  end

  state_t                  state, state_nxt;
  logic [IW-1:0]           owner, ptr, pick_idx;
  logic [REQ_NUM-1:0]      pick_grant;
  logic                    pick_any, accept;
  logic [DATA_WIDTH-1:0]   din_q, rsp_q, pick_din;
  logic [CW-1:0]           cnt;

`ifdef SHARE_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IW-1:0] rr_ptr;
  assign ptr = rr_ptr;

  // Rotate priority past the requester just served.
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (state == RESP)
      rr_ptr <= (owner == IW'(REQ_NUM - 1)) ? '0 : owner + 1'b1;
  end
`endif

  share_arb_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .IW      (IW)
  ) u_pick (
    .req   (req_vld),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign accept  = (state == IDLE) && !rst && pick_any;
  assign req_rdy = accept ? pick_grant : '0;

  // Select the winner's data slice.
  always_comb begin
    pick_din = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (pick_grant[i]) pick_din = req_din[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state logic for the accept/issue/wait/respond sequence.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus captured request, wait counter and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      din_q <= '0;
      rsp_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= pick_idx;
        din_q <= pick_din;
      end
      if (state == ISSUE)
        cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0)
        rsp_q <= res_dout;
    end
  end

  // Response pulse routed to the owner; suppressed while reset is held.
  always_comb begin
    rsp_vld = '0;
    if (state == RESP && !rst) rsp_vld[owner] = 1'b1;
  end

  assign res_vld  = (state == ISSUE);
  assign res_din  = din_q;
  assign rsp_dout = rsp_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_share_arb.sv
// Self-checking bench for share_arb (REQ_NUM=2, DATA_WIDTH=1, RES_LAT=2),
// plus RES_LAT=1 and RES_LAT=15 instances for the latency sweep.
// Resource model: res_dout = ~res_din delayed RES_LAT cycles.
module tb_share_arb;

  localparam int N   = 2;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_vld, req_din, req_rdy, rsp_vld;
  logic       rsp_dout, res_din, res_vld, res_dout, busy;

  always #5 clk = ~clk;

  share_arb #(.REQ_NUM(N), .DATA_WIDTH(1), .RES_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_din(req_din),
    .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_dout(rsp_dout),
    .res_din(res_din), .res_vld(res_vld), .res_dout(res_dout), .busy(busy)
  );

  logic [LAT-1:0] res_pipe = '0;
  always @(posedge clk) res_pipe <= {res_pipe[LAT-2:0], ~res_din};
  assign res_dout = res_pipe[LAT-1];

  // Latency-sweep instances
  logic [1:0] sw_vld [2];
  logic [1:0] sw_rdy [2];
  logic [1:0] sw_rspv [2];
  logic       sw_busy [2];
  logic       sw_resv [2];
  logic       sw_resdin [2];
  logic       sw_rspd [2];
  logic       sw_resdout [2];

  for (genvar g = 0; g < 2; g++) begin : g_sw
    logic [15:0] pipe = '0;
    share_arb #(.REQ_NUM(2), .DATA_WIDTH(1), .RES_LAT(g == 0 ? 1 : 15)) u_sw (
      .clk(clk), .rst(rst), .req_vld(sw_vld[g]), .req_din(2'b00),
      .req_rdy(sw_rdy[g]), .rsp_vld(sw_rspv[g]), .rsp_dout(sw_rspd[g]),
      .res_din(sw_resdin[g]), .res_vld(sw_resv[g]), .res_dout(sw_resdout[g]),
      .busy(sw_busy[g])
    );
    always @(posedge clk) pipe <= {pipe[14:0], ~sw_resdin[g]};
    assign sw_resdout[g] = pipe[g == 0 ? 0 : 14];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] vld;
    logic [1:0] din;
    logic [1:0] e_rdy;
    logic       e_resv;
    logic [1:0] e_rspv;
    logic       e_dout;
    logic       e_busy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] d,
                              input logic [1:0] rdy, input logic rv, input logic [1:0] sv,
                              input logic dd, input logic b);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d; t.e_rdy = rdy; t.e_resv = rv;
    t.e_rspv = sv; t.e_dout = dd; t.e_busy = b;
    return t;
  endfunction

  // Reference model: counts cycles since the accept instead of tracking states.
  int   m_since = -1;
  int   m_owner = 0;
  int   m_ptr   = 0;
  logic m_din   = 1'b0;
  logic m_rsp   = 1'b0;

  function automatic int pick(input logic [1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic sweep(input int k, input int lat);
    int n, bad, pulses;
    logic found;
    n = 0; bad = 0; pulses = 0; found = 1'b0;
    sw_vld[k] = 2'b01;
    @(negedge clk);
    chk($sformatf("sweep%0d.rdy", lat), 32'(sw_rdy[k]), 32'h1);
    @(posedge clk); #1;
    sw_vld[k] = 2'b11;
    while (!found && n < 40) begin
      n++;
      @(negedge clk);
      if (sw_busy[k] && sw_rdy[k] != 2'b00) bad++;
      if (sw_resv[k]) pulses++;
      if (sw_rspv[k] != 2'b00) begin
        found = 1'b1;
        chk($sformatf("sweep%0d.rspv", lat), 32'(sw_rspv[k]), 32'h1);
        chk($sformatf("sweep%0d.dout", lat), 32'(sw_rspd[k]), 32'h1);
      end
      @(posedge clk); #1;
    end
    sw_vld[k] = 2'b00;
    chk($sformatf("sweep%0d.latency", lat), 32'(n), 32'(lat + 2));
    chk($sformatf("sweep%0d.rdy_while_busy", lat), 32'(bad), 32'h0);
    chk($sformatf("sweep%0d.res_vld_pulses", lat), 32'(pulses), 32'h1);
    step();
  endtask

  initial begin
    vec_t tbl[$];
    logic [1:0] din_c;
    logic [1:0] pend, pdin;
    logic [1:0] exp_acc;

    req_vld = '0; req_din = '0;
    sw_vld[0] = '0; sw_vld[1] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ---- table-driven vectors ----
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 2'b01, 0, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b11, 2'b10, 2'b00, 0, 2'b00, 0, 0));
    din_c = 2'b10;
    for (int c = 0; c < 20; c++) begin
      int p, g, o, op;
      logic r, rp;
      p = c % 5; g = c / 5;
`ifdef SHARE_ARB_FIXED_PRIO_EN
      o = 0; op = 0;
`else
      o = g % 2; op = (g + 1) % 2;
`endif
      r  = ~din_c[o];
      rp = (g == 0) ? 1'b0 : ~din_c[op];
      tbl.push_back(mk(0, 2'b11, din_c, (p == 0) ? (2'b01 << o) : 2'b00, p == 1,
                       (p == 4) ? (2'b01 << o) : 2'b00, (p == 4) ? r : rp, p != 0));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; req_vld = tbl[i].vld; req_din = tbl[i].din;
      @(negedge clk);
      chk($sformatf("tbl%0d.rdy", i),  32'(req_rdy),  32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.resv", i), 32'(res_vld),  32'(tbl[i].e_resv));
      chk($sformatf("tbl%0d.rspv", i), 32'(rsp_vld),  32'(tbl[i].e_rspv));
      chk($sformatf("tbl%0d.dout", i), 32'(rsp_dout), 32'(tbl[i].e_dout));
      chk($sformatf("tbl%0d.busy", i), 32'(busy),     32'(tbl[i].e_busy));
      @(posedge clk); #1;
    end

    // ---- reset in the middle of a transaction ----
    rst = 1'b1; req_vld = '0; step(); rst = 1'b0;
    req_vld = 2'b01; req_din = 2'b00;
    @(negedge clk); chk("A.acc0", 32'(req_rdy), 32'h1); @(posedge clk); #1;
    req_vld = '0;
    repeat (4) step();
    req_vld = 2'b11; req_din = 2'b11;
`ifdef SHARE_ARB_FIXED_PRIO_EN
    exp_acc = 2'b01;
`else
    exp_acc = 2'b10;
`endif
    @(negedge clk); chk("A.acc1", 32'(req_rdy), 32'(exp_acc)); @(posedge clk); #1;
    req_vld = '0;
    @(negedge clk); chk("A.rspv_c1", 32'(rsp_vld), 32'h0); @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); chk("A.rspv_rst", 32'(rsp_vld), 32'h0); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("A.busy0", 32'(busy), 32'h0);
    chk("A.resv0", 32'(res_vld), 32'h0);
    chk("A.rspv0", 32'(rsp_vld), 32'h0);
    chk("A.dout0", 32'(rsp_dout), 32'h0);
    chk("A.resdin0", 32'(res_din), 32'h0);
    @(posedge clk); #1;
    req_vld = 2'b11; req_din = 2'b00;
    @(negedge clk); chk("A.ptr0", 32'(req_rdy), 32'h1); @(posedge clk); #1;
    req_vld = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) chk($sformatf("A.no_rsp%0d", k), 32'(rsp_vld), 32'h0);
      else begin
        chk("A.rsp_new", 32'(rsp_vld), 32'h1);
        chk("A.dout_new", 32'(rsp_dout), 32'h1);
      end
      @(posedge clk); #1;
    end

    // ---- withdrawn request while busy ----
    req_vld = 2'b01; req_din = 2'b00;
    @(negedge clk); chk("B.acc", 32'(req_rdy), 32'h1); @(posedge clk); #1;
    req_vld = '0; step();
    req_vld = 2'b10;
    @(negedge clk); chk("B.rdy_c2", 32'(req_rdy), 32'h0); @(posedge clk); #1;
    @(negedge clk); chk("B.rdy_c3", 32'(req_rdy), 32'h0); @(posedge clk); #1;
    req_vld = '0;
    @(negedge clk); chk("B.rsp", 32'(rsp_vld), 32'h1); @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("B.idle_busy%0d", k), 32'(busy), 32'h0);
      chk($sformatf("B.idle_rsp%0d", k), 32'(rsp_vld), 32'h0);
      @(posedge clk); #1;
    end

    // ---- latency sweep ----
    sweep(0, 1);
    sweep(1, 15);

    // ---- randomized traffic vs reference model ----
    rst = 1'b1; req_vld = '0; step(); rst = 1'b0;
    m_since = -1; m_owner = 0; m_ptr = 0; m_din = 1'b0; m_rsp = 1'b0;
    pend = '0; pdin = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int w, pe;
      logic idle;
      logic [1:0] e_rdy, e_rspv;
      rst = ($urandom_range(0, 99) == 0);
      req_vld = pend; req_din = pdin;
      @(negedge clk);
`ifdef SHARE_ARB_FIXED_PRIO_EN
      pe = 0;
`else
      pe = m_ptr;
`endif
      idle   = (m_since < 0);
      w      = pick(req_vld, pe);
      e_rdy  = (idle && !rst && w >= 0) ? (2'b01 << w) : 2'b00;
      e_rspv = (m_since == LAT + 2 && !rst) ? (2'b01 << m_owner) : 2'b00;
      chk("R.rdy",  32'(req_rdy),  32'(e_rdy));
      chk("R.busy", 32'(busy),     32'(!idle));
      chk("R.resv", 32'(res_vld),  32'(m_since == 1));
      chk("R.rspv", 32'(rsp_vld),  32'(e_rspv));
      chk("R.dout", 32'(rsp_dout), 32'(m_rsp));
      chk("R.resdin", 32'(res_din), 32'(m_din));
      if (rst) begin
        m_since = -1; m_owner = 0; m_ptr = 0; m_din = 1'b0; m_rsp = 1'b0;
      end else if (idle) begin
        if (w >= 0) begin
          m_since = 1; m_owner = w; m_din = req_din[w];
          pend[w] = 1'b0;
        end
      end else if (m_since == LAT + 2) begin
        m_since = -1;
        m_ptr = (m_owner + 1) % N;
      end else begin
        m_since++;
        if (m_since == LAT + 2) m_rsp = ~m_din;
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            pdin[i] = 1'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
